// File: rtl/miner_comm_pkg.sv
// Shared definitions for the miner host-communication path: nonce width,
// the empty-read sentinel and a constant-foldable clog2.
package miner_comm_pkg;

  localparam int unsigned NONCE_W = 32;
  localparam logic [NONCE_W-1:0] EMPTY_NONCE = 32'hFFFF_FFFF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nonce_sync_fifo.sv
// Single-clock FIFO with synchronous flush; occupancy is tracked separately
// from the wrapping pointers so full and empty need no extra pointer bit.
module nonce_sync_fifo
  import miner_comm_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = NONCE_W
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [clog2(DEPTH):0]    count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge hash_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/golden_nonce_reporter.sv
// Queues golden nonces from the hasher, drops back-to-back duplicates and
// serves them to the host with a 1-cycle read response and empty sentinel.
module golden_nonce_reporter
  import miner_comm_pkg::*;
#(
  parameter int unsigned        DEPTH       = 8,
  parameter logic [NONCE_W-1:0] EMPTY_VALUE = EMPTY_NONCE,
  parameter int unsigned        OVF_W       = 8
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  rx_new_nonce,
  input  logic [NONCE_W-1:0]    rx_golden_nonce,
  input  logic                  rx_new_work,
  input  logic                  rd_req,
  output logic                  rd_valid,
  output logic [NONCE_W-1:0]    rd_data,
  output logic                  rd_empty,
  output logic [clog2(DEPTH):0] fill_level,
  output logic [OVF_W-1:0]      overflow_count
);

  localparam logic [OVF_W-1:0] OVF_ONE = 1;

  logic [NONCE_W-1:0] last_nonce_q, last_nonce_d;
  logic               last_valid_q, last_valid_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic               rd_valid_q, rd_valid_d;
  logic [NONCE_W-1:0] rd_data_q, rd_data_d;
  logic               rd_empty_q, rd_empty_d;

  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic [NONCE_W-1:0] fifo_head;
  logic               is_dup, accept;

  nonce_sync_fifo #(.DEPTH(DEPTH), .W(NONCE_W)) u_fifo (
    .hash_clk  (hash_clk),
    .reset     (reset),
    .flush     (rx_new_work),
    .push      (fifo_push),
    .push_data (rx_golden_nonce),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level)
  );

  always_comb begin
    is_dup       = last_valid_q && (last_nonce_q == rx_golden_nonce);
    accept       = rx_new_nonce && !is_dup;
    fifo_pop     = rd_req && !fifo_empty && !rx_new_work;
    fifo_push    = accept && !rx_new_work;
    last_nonce_d = last_nonce_q;
    last_valid_d = last_valid_q;
    ovf_d        = ovf_q;
    rd_valid_d   = rd_req;
    rd_data_d    = rd_data_q;
    rd_empty_d   = rd_empty_q;

    if (rx_new_work) begin
      last_valid_d = 1'b0;
      ovf_d        = '0;
    end else if (accept) begin
      last_nonce_d = rx_golden_nonce;
      last_valid_d = 1'b1;
      if (fifo_full && !fifo_pop && ovf_q != '1) ovf_d = ovf_q + OVF_ONE;
    end

    // Pop is suppressed on a flush cycle, so that read reports empty.
    if (rd_req) begin
      if (fifo_pop) begin
        rd_data_d  = fifo_head;
        rd_empty_d = 1'b0;
      end else begin
        rd_data_d  = EMPTY_VALUE;
        rd_empty_d = 1'b1;
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      last_nonce_q <= '0;
      last_valid_q <= 1'b0;
      ovf_q        <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= EMPTY_VALUE;
      rd_empty_q   <= 1'b1;
    end else begin
      last_nonce_q <= last_nonce_d;
      last_valid_q <= last_valid_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_empty_q   <= rd_empty_d;
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign rd_empty       = rd_empty_q;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Directed bench for golden_nonce_reporter with DEPTH=8 and hand-computed expectations.
module tb_golden_nonce_reporter;

  logic        hash_clk = 1'b0;
  logic        reset;
  logic        rx_new_nonce;
  logic [31:0] rx_golden_nonce;
  logic        rx_new_work;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic [3:0]  fill_level;
  logic [7:0]  overflow_count;

  int n_tests = 0;
  int n_fail  = 0;

  golden_nonce_reporter #(.DEPTH(8), .EMPTY_VALUE(32'hFFFF_FFFF), .OVF_W(8)) dut (
    .hash_clk        (hash_clk),
    .reset           (reset),
    .rx_new_nonce    (rx_new_nonce),
    .rx_golden_nonce (rx_golden_nonce),
    .rx_new_work     (rx_new_work),
    .rd_req          (rd_req),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .fill_level      (fill_level),
    .overflow_count  (overflow_count)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic tick();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] n);
    rx_new_nonce    = 1'b1;
    rx_golden_nonce = n;
    tick();
    rx_new_nonce    = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] exp_data, input logic exp_empty);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"},  rd_data, exp_data);
    check({tag, "_empty"}, {31'd0, rd_empty}, {31'd0, exp_empty});
  endtask

  initial begin
    reset = 1'b1; rx_new_nonce = 1'b0; rx_golden_nonce = '0;
    rx_new_work = 1'b0; rd_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_data",  rd_data, 32'hFFFF_FFFF);
    check("rst_empty", {31'd0, rd_empty}, 32'd1);
    check("rst_fill",  {28'd0, fill_level}, 32'd0);
    check("rst_ovf",   {24'd0, overflow_count}, 32'd0);

    read_check("empty_rd", 32'hFFFF_FFFF, 1'b1);
    check("empty_rd_fill", {28'd0, fill_level}, 32'd0);

    // Basic ordering with back-to-back reads
    push(32'h10); push(32'h20); push(32'h30);
    check("ord_fill3", {28'd0, fill_level}, 32'd3);
    read_check("ord_r0", 32'h10, 1'b0);
    read_check("ord_r1", 32'h20, 1'b0);
    read_check("ord_r2", 32'h30, 1'b0);
    check("ord_fill0", {28'd0, fill_level}, 32'd0);
    read_check("ord_r3", 32'hFFFF_FFFF, 1'b1);

    // Back-to-back duplicate removal only
    push(32'h1234); push(32'h1234); push(32'h5678); push(32'h1234);
    check("dup_fill", {28'd0, fill_level}, 32'd3);
    read_check("dup_r0", 32'h1234, 1'b0);
    read_check("dup_r1", 32'h5678, 1'b0);
    read_check("dup_r2", 32'h1234, 1'b0);
    check("dup_ovf", {24'd0, overflow_count}, 32'd0);

    // Overflow: 10 pushes into 8 entries
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    check("ovf_fill", {28'd0, fill_level}, 32'd8);
    check("ovf_cnt",  {24'd0, overflow_count}, 32'd2);
    rx_new_nonce = 1'b1; rx_golden_nonce = 32'h200;
    read_check("ovf_pp", 32'h100, 1'b0);
    rx_new_nonce = 1'b0;
    check("ovf_pp_fill", {28'd0, fill_level}, 32'd8);
    check("ovf_pp_cnt",  {24'd0, overflow_count}, 32'd2);
    for (int i = 1; i < 8; i++) read_check("ovf_rd", 32'h100 + 32'(i), 1'b0);
    read_check("ovf_last", 32'h200, 1'b0);
    check("ovf_drain", {28'd0, fill_level}, 32'd0);

    // Flush with coincident push and read
    for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
    check("fl_fill5", {28'd0, fill_level}, 32'd5);
    rx_new_work = 1'b1; rx_new_nonce = 1'b1; rx_golden_nonce = 32'hAAAA;
    read_check("fl_rd", 32'hFFFF_FFFF, 1'b1);
    rx_new_work = 1'b0; rx_new_nonce = 1'b0;
    check("fl_fill0", {28'd0, fill_level}, 32'd0);
    check("fl_ovf0",  {24'd0, overflow_count}, 32'd0);
    push(32'hAAAA);
    check("fl_fill1", {28'd0, fill_level}, 32'd1);
    read_check("fl_aaaa", 32'hAAAA, 1'b0);

    // No bypass: push and read on an empty FIFO
    rx_new_nonce = 1'b1; rx_golden_nonce = 32'hBEEF;
    read_check("nb_rd", 32'hFFFF_FFFF, 1'b1);
    rx_new_nonce = 1'b0;
    check("nb_fill", {28'd0, fill_level}, 32'd1);
    read_check("nb_beef", 32'hBEEF, 1'b0);

    // Mid-stream reset with rd_req high
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(i));
    check("mr_fill4", {28'd0, fill_level}, 32'd4);
    reset = 1'b1; rd_req = 1'b1;
    tick();
    reset = 1'b0; rd_req = 1'b0;
    check("mr_valid", {31'd0, rd_valid}, 32'd0);
    check("mr_data",  rd_data, 32'hFFFF_FFFF);
    check("mr_empty", {31'd0, rd_empty}, 32'd1);
    check("mr_fill",  {28'd0, fill_level}, 32'd0);
    check("mr_ovf",   {24'd0, overflow_count}, 32'd0);
    push(32'hFFFF_FFFF);
    read_check("mr_ffff", 32'hFFFF_FFFF, 1'b0);
    read_check("mr_sent", 32'hFFFF_FFFF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/golden_nonce_reporter.md
Name: golden_nonce_reporter

Overview:
- Consumer end of the miner's golden-nonce path: accepts the hash-domain new-nonce strobe and the nonce value from the mining top level, and queues the nonces.
- Serves the queued nonces to the host-communication logic through a single-clock read handshake.
- Removes back-to-back duplicates, flushes on new work, counts drops, and returns an empty sentinel so the host polling loop needs no extra flag.
- Sits between the hasher control unit and the JTAG/serial register interface, entirely in the hash_clk domain.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- EMPTY_VALUE, 32'hFFFFFFFF, rd_data value returned when a read finds the FIFO empty.
- OVF_W, 8, width of the saturating overflow counter.

Ports:
- hash_clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- rx_new_nonce  input  1  one-cycle strobe: rx_golden_nonce is valid this cycle.
- rx_golden_nonce  input  32  candidate nonce.
- rx_new_work  input  1  one-cycle strobe: new work loaded; flush.
- rd_req  input  1  host read request, one cycle per read.
- rd_valid  output  1  pulses one cycle after each rd_req.
- rd_data  output  32  nonce, or EMPTY_VALUE; held until the next read.
- rd_empty  output  1  qualifies rd_data; 1 means the read found the FIFO empty.
- fill_level  output  log2(DEPTH)+1  current occupancy.
- overflow_count  output  OVF_W  nonces dropped because the FIFO was full; saturates at all-ones.

Behaviour:
- Reset values:
  - rd_valid=0, rd_data=EMPTY_VALUE, rd_empty=1, fill_level=0, overflow_count=0.
  - FIFO pointers are zero; the last-nonce register is invalid.
- Priority each cycle: reset > rx_new_work flush > normal push/pop.
- Flush (rx_new_work=1):
  - Pointers and fill_level go to 0; the last-nonce register is invalidated; overflow_count is cleared.
  - A push in the same cycle is discarded.
  - A rd_req in the same cycle gives rd_valid=1, rd_empty=1, rd_data=EMPTY_VALUE on the next cycle.
- Push:
  - Occurs when rx_new_nonce=1 and the nonce is not a duplicate.
  - Duplicate means the last-nonce register is valid and equals rx_golden_nonce. Duplicates are dropped silently and are not counted.
  - Every non-duplicate strobe updates the last-nonce register, whether or not the push succeeds.
- Full FIFO:
  - If fill_level==DEPTH and no pop occurs this cycle, the push is dropped and overflow_count increments, saturating.
  - If a pop occurs in the same cycle, the push is accepted and fill_level stays at DEPTH.
- Read (rd_req=1): one cycle later, rd_valid=1.
  - Non-empty FIFO: rd_data is the head entry, rd_empty=0, the head is popped, and fill_level decrements unless a push occurs in the same cycle.
  - Empty FIFO: rd_data=EMPTY_VALUE, rd_empty=1.
- No bypass: a push and a read in the same cycle on an empty FIFO gives a read result of empty, and the pushed nonce is stored with fill_level=1.
- Ordering is strict FIFO. Read latency is fixed at 1 cycle. Push-to-readable latency is 1 cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; fill_level is maintained separately, with simultaneous push and pop leaving it unchanged.
- A nonce equal to EMPTY_VALUE is a legal nonce. The host distinguishes it from the sentinel via rd_empty.
- rd_req on back-to-back cycles is legal; each request pops one entry.

Decomposition:
- Shared package miner_comm_pkg holds NONCE_W=32, the EMPTY_NONCE constant (32'hFFFFFFFF) and the clog2 helper. Both the comm block and this block import it.
- One sub-module, nonce_sync_fifo: a single-clock FIFO with push, pop, flush, full, empty and count.
- Dedupe, the overflow counter and the read-response register stay in golden_nonce_reporter.

Test Plan:
- Reset, then rd_req → next cycle rd_valid=1, rd_empty=1, rd_data=32'hFFFFFFFF, fill_level=0.
- Push strobes 0x00000010, 0x00000020, 0x00000030, then 3 rd_req → data returned in that order, rd_empty=0 each time, fill_level ends at 0; a 4th read returns EMPTY_VALUE.
- Push 0x1234 on two consecutive strobes, then 0x5678, then 0x1234 → fill_level=3; reads return 0x1234, 0x5678, 0x1234; overflow_count=0.
- Push 10 distinct nonces with DEPTH=8 and no reads → fill_level=8, overflow_count=2; reads return the first 8; a push coincident with a pop while full is accepted.
- Fill with 5 entries, then assert rx_new_work together with rx_new_nonce=0xAAAA and rd_req → next cycle rd_empty=1; fill_level=0, overflow_count=0; 0xAAAA is not stored; a following push of 0xAAAA is accepted.
- Assert reset mid-stream with fill_level=4 and rd_req high → the next cycle shows all reset values and rd_valid=0; a later push of 0xFFFFFFFF reads back with rd_empty=0.
